modrm_decode: RTL and testbench
===============================

Name: modrm_decode

Overview:
- Decodes the x86 ModR/M byte and any displacement bytes taken from the prefetch FIFO.
- Computes the 16-bit effective address from the register file's dedicated bx/bp/si/di outputs.
- Drives the register-file read selects for the reg and r/m fields.
- Sits between the instruction prefetch FIFO and the microcode sequencer. The sequencer pulses start and waits for complete.

Parameters:
None.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  begin decode; sampled only in IDLE
clear  input  1  synchronous abort to IDLE (pipeline flush)
fifo_rd_data  input  8  head byte of prefetch FIFO, show-ahead (valid whenever !fifo_empty)
fifo_empty  input  1  FIFO has no byte
fifo_rd_en  output  1  pop head byte this cycle (combinational)
si, di, bp, bx  input  16 each  register-file dedicated outputs
reg  output  3  modrm[5:3]
rm_regnum  output  3  modrm[2:0]
rm_is_reg  output  1  mod==2'b11
effective_address  output  16  computed EA
bp_as_base  output  1  EA uses BP as base (SS default segment)
busy  output  1  state != IDLE
complete  output  1  one-cycle pulse: outputs valid

Behaviour:
- Reset: state IDLE. All outputs are 0, including complete, busy, fifo_rd_en and every latched field.

- States:
  - IDLE: start && !clear -> READ_MODRM.
  - READ_MODRM: if !fifo_empty, pop the byte and latch it as modrm. On the same edge reg, rm_regnum and rm_is_reg update. Next state:
    - mod=11 -> CALC
    - mod=00, rm!=110 -> CALC
    - mod=01 -> DISP_LO
    - mod=10 -> DISP_LO
    - mod=00, rm=110 -> DISP_LO
  - DISP_LO: if !fifo_empty, pop and latch disp[7:0].
    - mod=01 -> disp[15:8] = {8{byte[7]}} (sign extend), then CALC.
    - Otherwise -> DISP_HI.
  - DISP_HI: if !fifo_empty, pop and latch disp[15:8], then CALC.
  - CALC: register effective_address and bp_as_base, assert complete for the next cycle, then go to IDLE.
- fifo_rd_en = !fifo_empty && state is one of READ_MODRM, DISP_LO, DISP_HI && !clear. Never assert while empty. While empty, stay in the same state; no timeout.

- EA, computed with 16-bit modulo arithmetic (carry discarded), disp = 0 when mod=00 and rm!=110:
  - rm 000: bx+si+disp
  - rm 001: bx+di+disp
  - rm 010: bp+si+disp
  - rm 011: bp+di+disp
  - rm 100: si+disp
  - rm 101: di+disp
  - rm 110: bp+disp, or disp alone when mod=00
  - rm 111: bx+disp
- mod=11: effective_address = 0 and bp_as_base = 0.
- bp_as_base = 1 for rm 010 and 011, and for rm 110 with mod!=00. Otherwise 0.
- si/di/bp/bx are sampled in CALC only. The sequencer guarantees any pending register write has been visible for at least one cycle before start.

- Latency from the start edge to complete high, with no stalls:
  - mod=11 or no displacement: 3 cycles
  - disp8: 4 cycles
  - disp16 or direct: 5 cycles
  - Each empty-FIFO cycle adds 1.
- Outputs hold their values after complete until the next latch. complete is exactly one cycle wide.

- start while busy: ignored.
- clear in any state: next state IDLE, no pop that cycle, complete not asserted. Latched outputs keep their values. clear && start in IDLE: clear wins.
- clear during CALC: complete is suppressed.
- reset mid-operation: immediate return to IDLE with zeroed outputs. No pop after reset deasserts until a new start.

Test Plan:
- mod=11: FIFO [0xC3], start -> one pop; rm_is_reg=1, rm_regnum=3, reg=0, effective_address=0; complete 3 cycles after start.
- Base+index, no disp: bx=0x1000, si=0x0234, FIFO [0x00] -> EA=0x1234, bp_as_base=0, one pop, latency 3.
- disp8 negative: bp=0x2000, FIFO [0x46, 0xFE] -> EA=0x1FFE, bp_as_base=1, reg=0, two pops, latency 4.
- Direct address: FIFO [0x06, 0x34, 0x12], bp=0xFFFF -> EA=0x1234, bp_as_base=0, three pops, latency 5. Repeat with modrm 0x86 (mod=10, rm=110) and bp=0x0100 -> EA=0x1334, bp_as_base=1.
- Wrap and stall: bx=0xFFFF, si=0x0002, FIFO [0x80] then 0x01 and 0x00 with fifo_empty held for 3 cycles before each displacement byte -> fifo_rd_en never high while empty, EA=0x0002, latency 11.
- Abort: clear asserted in DISP_HI -> IDLE next cycle, no complete, remaining byte not popped. Reset asserted in DISP_LO -> all outputs 0 immediately. A new start after either then decodes correctly.

Source files
------------

// File: rtl/modrm_decode.sv
// x86 ModR/M decoder: pops ModR/M and displacement bytes from the prefetch FIFO and computes the 16-bit EA.
// The ModR/M reg field is exposed as reg_field because "reg" is a reserved word.
module modrm_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        clear,
  input  logic [7:0]  fifo_rd_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [15:0] si,
  input  logic [15:0] di,
  input  logic [15:0] bp,
  input  logic [15:0] bx,
  output logic [2:0]  reg_field,
  output logic [2:0]  rm_regnum,
  output logic        rm_is_reg,
  output logic [15:0] effective_address,
  output logic        bp_as_base,
  output logic        busy,
  output logic        complete
);

  typedef enum logic [2:0] {
    IDLE,
    READ_MODRM,
    DISP_LO,
    DISP_HI,
    CALC
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  mod_q;
  logic [15:0] disp;
  logic [1:0]  byte_mod;
  logic [2:0]  byte_rm;
  logic [15:0] disp_eff;
  logic [15:0] base;
  logic [15:0] ea_next;
  logic        bp_next;

  assign byte_mod  = fifo_rd_data[7:6];
  assign byte_rm   = fifo_rd_data[2:0];
  assign busy      = (state != IDLE);
  assign rm_is_reg = (mod_q == 2'b11);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = READ_MODRM;
      end
      READ_MODRM: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          if (byte_mod == 2'b11 || (byte_mod == 2'b00 && byte_rm != 3'b110))
            state_next = CALC;
          else
            state_next = DISP_LO;
        end
      end
      DISP_LO: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_next = (mod_q == 2'b01) ? CALC : DISP_HI;
        end
      end
      DISP_HI: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_next = CALC;
        end
      end
      CALC:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A flush overrides everything, including a start seen in IDLE.
    if (clear) begin
      state_next = IDLE;
      fifo_rd_en = 1'b0;
    end
  end

  // The displacement register may hold a stale value from an earlier decode; mod=00 without direct addressing ignores it.
  always_comb begin
    disp_eff = (mod_q == 2'b00 && rm_regnum != 3'b110) ? 16'h0000 : disp;
    base     = 16'h0000;
    bp_next  = 1'b0;
    case (rm_regnum)
      3'b000: base = bx + si;
      3'b001: base = bx + di;
      3'b010: begin base = bp + si; bp_next = 1'b1; end
      3'b011: begin base = bp + di; bp_next = 1'b1; end
      3'b100: base = si;
      3'b101: base = di;
      3'b110: begin
        if (mod_q != 2'b00) begin
          base    = bp;
          bp_next = 1'b1;
        end
      end
      default: base = bx;
    endcase
    ea_next = base + disp_eff;
    if (mod_q == 2'b11) begin
      ea_next = 16'h0000;
      bp_next = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      mod_q             <= 2'b00;
      reg_field         <= 3'b000;
      rm_regnum         <= 3'b000;
      disp              <= 16'h0000;
      effective_address <= 16'h0000;
      bp_as_base        <= 1'b0;
      complete          <= 1'b0;
    end else begin
      state    <= state_next;
      complete <= (state == CALC) && !clear;
      if (fifo_rd_en) begin
        case (state)
          READ_MODRM: begin
            mod_q     <= byte_mod;
            reg_field <= fifo_rd_data[5:3];
            rm_regnum <= byte_rm;
          end
          // Sign extension here is correct for disp8; disp16 overwrites the high byte next.
          DISP_LO: disp    <= {{8{fifo_rd_data[7]}}, fifo_rd_data};
          DISP_HI: disp[15:8] <= fifo_rd_data;
          default: ;
        endcase
      end
      if (state == CALC && !clear) begin
        effective_address <= ea_next;
        bp_as_base        <= bp_next;
      end
    end
  end

endmodule

// File: tb/tb_modrm_decode.sv
// Directed bench for modrm_decode: a modelled show-ahead FIFO with per-byte stalls feeds hand-computed vectors.
module tb_modrm_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        clear;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [15:0] si, di, bp, bx;
  logic [2:0]  reg_field;
  logic [2:0]  rm_regnum;
  logic        rm_is_reg;
  logic [15:0] effective_address;
  logic        bp_as_base;
  logic        busy;
  logic        complete;

  int checks = 0;
  int fails = 0;
  int pops = 0;
  int rd_while_empty = 0;
  logic [7:0] data_q[$];
  int         stall_q[$];

  always #5 clk = ~clk;

  modrm_decode dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .si(si), .di(di), .bp(bp), .bx(bx),
    .reg_field(reg_field), .rm_regnum(rm_regnum), .rm_is_reg(rm_is_reg),
    .effective_address(effective_address), .bp_as_base(bp_as_base),
    .busy(busy), .complete(complete)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present the FIFO head; a head byte with a stall count stays hidden for that many cycles.
  task automatic refresh(input bit dec);
    if (data_q.size() == 0) begin
      fifo_empty   = 1'b1;
      fifo_rd_data = 8'h00;
    end else if (stall_q[0] > 0) begin
      fifo_empty   = 1'b1;
      fifo_rd_data = 8'h00;
      if (dec) stall_q[0] = stall_q[0] - 1;
    end else begin
      fifo_empty   = 1'b0;
      fifo_rd_data = data_q[0];
    end
  endtask

  task automatic push(input logic [7:0] b, input int stall);
    data_q.push_back(b);
    stall_q.push_back(stall);
    refresh(1'b0);
  endtask

  task automatic flush();
    data_q.delete();
    stall_q.delete();
    refresh(1'b0);
  endtask

  task automatic tick();
    logic pop_req;
    logic emp;
    #1;
    pop_req = fifo_rd_en;
    emp     = fifo_empty;
    @(posedge clk);
    #1;
    if (pop_req) begin
      if (emp) begin
        rd_while_empty++;
      end else begin
        void'(data_q.pop_front());
        void'(stall_q.pop_front());
        pops++;
      end
    end
    refresh(1'b1);
  endtask

  // Latency counts clock edges from the one that samples start up to the edge after which complete is high.
  task automatic run_op(input int exp_lat, input int exp_pops);
    int lat;
    int p0;
    p0 = pops;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!complete && lat < 60) begin
      tick();
      lat++;
    end
    check("latency", lat, exp_lat);
    check("pops", pops - p0, exp_pops);
  endtask

  task automatic check_pulse_end();
    tick();
    check("complete_width", complete, 1'b0);
    check("busy_after", busy, 1'b0);
  endtask

  task automatic set_regs(input logic [15:0] v_bx, input logic [15:0] v_bp,
                          input logic [15:0] v_si, input logic [15:0] v_di);
    bx = v_bx; bp = v_bp; si = v_si; di = v_di;
  endtask

  initial begin
    int seen;
    int p0;
    reset = 1'b1; start = 1'b0; clear = 1'b0;
    set_regs(16'h0, 16'h0, 16'h0, 16'h0);
    refresh(1'b0);
    tick(); tick();
    check("rst_complete", complete, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", fifo_rd_en, 1'b0);
    check("rst_ea", effective_address, 16'h0);
    check("rst_fields", {reg_field, rm_regnum, rm_is_reg, bp_as_base}, 8'h00);
    reset = 1'b0;
    tick();

    // Register operand.
    push(8'hC3, 0);
    run_op(3, 1);
    check("c3_is_reg", rm_is_reg, 1'b1);
    check("c3_rm", rm_regnum, 3'd3);
    check("c3_reg", reg_field, 3'd0);
    check("c3_ea", effective_address, 16'h0);
    check_pulse_end();

    // [bx+si]
    set_regs(16'h1000, 16'h0, 16'h0234, 16'h0);
    push(8'h00, 0);
    run_op(3, 1);
    check("bxsi_ea", effective_address, 16'h1234);
    check("bxsi_bp", bp_as_base, 1'b0);
    check("bxsi_is_reg", rm_is_reg, 1'b0);
    check_pulse_end();

    // [bp-2]
    set_regs(16'h0, 16'h2000, 16'h0, 16'h0);
    push(8'h46, 0); push(8'hFE, 0);
    run_op(4, 2);
    check("d8_ea", effective_address, 16'h1FFE);
    check("d8_bp", bp_as_base, 1'b1);
    check("d8_reg", reg_field, 3'd0);
    check_pulse_end();

    // Direct address ignores bp.
    set_regs(16'h0, 16'hFFFF, 16'h0, 16'h0);
    push(8'h06, 0); push(8'h34, 0); push(8'h12, 0);
    run_op(5, 3);
    check("dir_ea", effective_address, 16'h1234);
    check("dir_bp", bp_as_base, 1'b0);
    check_pulse_end();

    // [bp+disp16]
    set_regs(16'h0, 16'h0100, 16'h0, 16'h0);
    push(8'h86, 0); push(8'h34, 0); push(8'h12, 0);
    run_op(5, 3);
    check("bpd16_ea", effective_address, 16'h1334);
    check("bpd16_bp", bp_as_base, 1'b1);
    check_pulse_end();

    // [bx] with a stale displacement still held from the previous decode.
    set_regs(16'h4000, 16'h0, 16'h0, 16'h0);
    push(8'h07, 0);
    run_op(3, 1);
    check("bx_ea", effective_address, 16'h4000);
    check("bx_rm", rm_regnum, 3'd7);
    check_pulse_end();

    // [si-0x80]
    set_regs(16'h0, 16'h0, 16'h0100, 16'h0);
    push(8'h44, 0); push(8'h80, 0);
    run_op(4, 2);
    check("sid8_ea", effective_address, 16'h0080);
    check("sid8_bp", bp_as_base, 1'b0);
    check_pulse_end();

    // Wrap-around with 3 empty cycles before each displacement byte.
    set_regs(16'hFFFF, 16'h0, 16'h0002, 16'h0);
    push(8'h80, 0); push(8'h01, 3); push(8'h00, 3);
    run_op(11, 3);
    check("wrap_ea", effective_address, 16'h0002);
    check("wrap_bp", bp_as_base, 1'b0);
    check("wrap_rd_empty", rd_while_empty, 0);
    check_pulse_end();

    // Clear while waiting for the disp16 high byte.
    push(8'h06, 0); push(8'h34, 0); push(8'h12, 0);
    p0 = pops;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    clear = 1'b1;
    #1;
    check("clr_rd_en", fifo_rd_en, 1'b0);
    tick();
    clear = 1'b0;
    check("clr_busy", busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (complete) seen++;
    end
    check("clr_no_complete", seen, 0);
    check("clr_pops", pops - p0, 2);
    check("clr_left", data_q.size(), 1);
    check("clr_rm_held", rm_regnum, 3'd6);
    check("clr_ea_held", effective_address, 16'h0002);
    flush();

    // Fresh decode after the abort: [bp+si+0x10], reg=3.
    set_regs(16'h0, 16'h0100, 16'h0020, 16'h0);
    push(8'h5A, 0); push(8'h10, 0);
    run_op(4, 2);
    check("post_clr_ea", effective_address, 16'h0130);
    check("post_clr_bp", bp_as_base, 1'b1);
    check("post_clr_reg", reg_field, 3'd3);
    check("post_clr_rm", rm_regnum, 3'd2);
    check_pulse_end();

    // Clear in CALC suppresses complete and leaves the EA untouched.
    push(8'hC0, 0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clrcalc_complete", complete, 1'b0);
    check("clrcalc_ea", effective_address, 16'h0130);
    tick();
    check("clrcalc_complete2", complete, 1'b0);

    // start together with clear in IDLE does nothing.
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    check("startclr_busy", busy, 1'b0);

    // Reset while stalled in DISP_LO.
    set_regs(16'h0, 16'h2000, 16'h0, 16'h0);
    push(8'h46, 0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ea", effective_address, 16'h0);
    check("mid_rst_fields", {reg_field, rm_regnum, rm_is_reg, bp_as_base}, 8'h00);
    check("mid_rst_rd_en", fifo_rd_en, 1'b0);
    push(8'hFE, 0);
    p0 = pops;
    #3;
    reset = 1'b0;
    tick(); tick(); tick();
    check("post_rst_no_pop", pops - p0, 0);
    check("post_rst_busy", busy, 1'b0);
    flush();

    // Fresh decode after reset: [bx+di].
    set_regs(16'h1111, 16'h0, 16'h0, 16'h2222);
    push(8'h01, 0);
    run_op(3, 1);
    check("post_rst_ea", effective_address, 16'h3333);
    check("post_rst_bpb", bp_as_base, 1'b0);
    check_pulse_end();

    check("rd_en_while_empty", rd_while_empty, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
